// File: rtl/gpio_capture_pkg.sv
// +----------------------------------------------------------------------------+
// | gpio_capture_pkg : shared FSM, mode and FIFO-entry types for GPIO capture  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package gpio_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_CHANGE = 1'b0,
    MODE_EXTCLK = 1'b1
  } mode_e;

  localparam int unsigned C_DEFAULT_WIDTH = 32;

  typedef struct packed {
    logic [C_DEFAULT_WIDTH-1:0] data;
    logic                       ext_clk;
  } capture_entry_t;

endpackage

`default_nettype wire

// File: rtl/gpio_capture_fifo.sv
// +----------------------------------------------------------------------------+
// | gpio_capture_fifo : DEPTH-entry synchronous show-ahead FIFO with level     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gpio_capture_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_LVL_W = $clog2(DEPTH) + 1;

  logic [DW-1:0]      mem_q [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_LVL_W-1:0] level_q, level_d;
  logic               w_wr_en;
  logic               w_rd_en;

  assign full_o      = (level_q == C_LVL_W'(DEPTH));
  assign empty_o     = (level_q == '0);
  assign level_o     = level_q;
  assign head_data_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign w_wr_en = push_i && (!full_o || pop_i);
  assign w_rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_wr_en) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
    if (w_rd_en) rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
    case ({w_wr_en, w_rd_en})
      2'b10:   level_d = level_q + C_LVL_W'(1);
      2'b01:   level_d = level_q - C_LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (w_wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpio_change_capture.sv
// +----------------------------------------------------------------------------+
// | gpio_change_capture : synchronised GPIO/ext_clk event capture into a FIFO  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gpio_change_capture
  import gpio_capture_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   mode_i,
  input  logic [WIDTH-1:0]       gpio_in_i,
  input  logic                   ext_clk_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [WIDTH-1:0]       evt_data_o,
  output logic                   evt_ext_clk_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   overflow_o,
  input  logic                   overflow_clr_i
);

  // Same layout as capture_entry_t, but sized by WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             ext_clk;
  } entry_t;

  logic [WIDTH-1:0]       gpio_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [WIDTH-1:0]       w_gpio_s;
  logic                   w_ext_s;

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [WIDTH-1:0] last_sample_q;
  logic             last_ext_q;
  logic             overflow_q, overflow_d;

  logic   w_init_load;
  logic   w_capture_en;
  logic   w_push;
  logic   w_push_ext;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  entry_t w_push_entry;
  entry_t w_head_entry;

  assign w_gpio_s = gpio_sync_q[SYNC_STAGES-1];
  assign w_ext_s  = ext_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) gpio_sync_q[i] <= '0;
      ext_sync_q <= '0;
    end else begin
      gpio_sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) gpio_sync_q[i] <= gpio_sync_q[i-1];
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_clk_i};
    end
  end

  always_comb begin
    state_d      = state_q;
    w_init_load  = 1'b0;
    w_capture_en = 1'b0;
    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_INIT;
      ST_INIT: begin
        w_init_load = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i)                    state_d = ST_IDLE;
        else if (mode_e'(mode_i) != mode_q) state_d = ST_INIT;
        else                              w_capture_en = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_push     = 1'b0;
    w_push_ext = 1'b0;
    if (w_capture_en) begin
      if (mode_q == MODE_CHANGE) begin
        w_push = (w_gpio_s != last_sample_q);
      end else if (w_ext_s != last_ext_q) begin
        w_push     = 1'b1;
        w_push_ext = w_ext_s;
      end
    end
  end

  assign w_pop        = evt_valid_o && evt_ready_i;
  assign w_push_entry = '{data: w_gpio_s, ext_clk: w_push_ext};

  // Set wins over clear when a drop coincides with overflow_clr.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr_i)                 overflow_d = 1'b0;
    if (w_push && w_full && !w_pop)     overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_CHANGE;
      last_sample_q <= '0;
      last_ext_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      if (w_init_load) mode_q <= mode_e'(mode_i);
      if (w_init_load || w_capture_en) begin
        last_sample_q <= w_gpio_s;
        last_ext_q    <= w_ext_s;
      end
    end
  end

  gpio_capture_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_data_o (w_head_entry),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (fifo_level_o)
  );

  assign evt_valid_o   = !w_empty;
  assign evt_data_o    = w_head_entry.data;
  assign evt_ext_clk_o = w_head_entry.ext_clk;
  assign overflow_o    = overflow_q;

endmodule

`default_nettype wire
